// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU datapath: FSM encoding, error codes, widths.
package cpu_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 32;
    localparam int CNT_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_ALIGN    = 2'd1,
        ERR_CONFLICT = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } err_t;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Counts BUSY cycles; tc flags the last allowed cycle before the access is aborted.
module mem_timeout_cnt
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    // cnt holds the number of BUSY cycles already elapsed, so TIMEOUT-1 marks the final one
    assign tc = en && (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port.sv
// Memory access stage: turns controller strobes into a handshaked memory request and owns IR/MDR.
module mem_port
    import cpu_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              lorD,
    input  logic              IRWrite,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] alu_out,
    input  logic [DATA_W-1:0] wdata,
    output logic              stall,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] mdr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [1:0]        err,
    input  logic              err_clr
);

    state_t            state;
    err_t              err_q;
    err_t              new_err;
    logic              ir_sel;
    logic              tc;
    logic [ADDR_W-1:0] addr_sel;
    logic              one_strobe;
    logic              conflict;
    logic              aligned;
    logic              start;

    assign addr_sel   = lorD ? alu_out : pc;
    assign one_strobe = MemRead ^ MemWrite;
    assign conflict   = MemRead & MemWrite;
    assign aligned    = (addr_sel[1:0] == 2'b00);
    assign start      = (state == ST_IDLE) && one_strobe && aligned;

    // stall must rise in the strobe cycle itself so the controller does not advance
    assign stall = start || (state == ST_BUSY);
    assign err   = err_q;

    mem_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (state != ST_BUSY),
        .en  (state == ST_BUSY),
        .tc  (tc)
    );

    always_comb begin
        new_err = ERR_NONE;
        if (state == ST_IDLE) begin
            if (conflict) begin
                new_err = ERR_CONFLICT;
            end else if (one_strobe && !aligned) begin
                new_err = ERR_ALIGN;
            end
        end else if (state == ST_BUSY && !mem_ready && tc) begin
            new_err = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ir_sel    <= 1'b0;
            ir        <= '0;
            mdr       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_BUSY;
                        mem_req   <= 1'b1;
                        mem_we    <= MemWrite;
                        mem_addr  <= addr_sel;
                        mem_wdata <= wdata;
                        ir_sel    <= IRWrite;
                    end
                end
                ST_BUSY: begin
                    // a response on the terminal cycle still completes the access
                    if (mem_ready) begin
                        state   <= ST_DONE;
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            if (ir_sel) ir  <= mem_rdata;
                            else        mdr <= mem_rdata;
                        end
                    end else if (tc) begin
                        state   <= ST_DONE;
                        mem_req <= 1'b0;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // first error sticks; a new error arriving with err_clr replaces the cleared one
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= ERR_NONE;
        end else if (new_err != ERR_NONE && (err_q == ERR_NONE || err_clr)) begin
            err_q <= new_err;
        end else if (err_clr) begin
            err_q <= ERR_NONE;
        end
    end

endmodule

// File: tb/tb_mem_port.sv
// Directed bench for mem_port: fetch, load with wait states, store, errors, timeout, reset abort.
module tb_mem_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead, MemWrite, lorD, IRWrite;
    logic [31:0] pc, alu_out, wdata;
    logic        stall;
    logic [31:0] ir, mdr;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ready;
    logic [1:0]  err;
    logic        err_clr;

    int n_vec = 0;
    int n_err = 0;

    mem_port #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .lorD      (lorD),
        .IRWrite   (IRWrite),
        .pc        (pc),
        .alu_out   (alu_out),
        .wdata     (wdata),
        .stall     (stall),
        .ir        (ir),
        .mdr       (mdr),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .err       (err),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b0; MemRead = 0; MemWrite = 0; lorD = 0; IRWrite = 0;
        pc = '0; alu_out = '0; wdata = '0; mem_rdata = '0; mem_ready = 0; err_clr = 0;
        #12;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_ir", ir, 32'd0);
        chk("rst_mdr", mdr, 32'd0);
        chk("rst_err", {30'd0, err}, 32'd0);
        rst = 1'b1;
        cyc();

        // fetch
        MemRead = 1; IRWrite = 1; lorD = 0; pc = 32'h40;
        #1; chk("fetch_stall_n", {31'd0, stall}, 32'd1);
        chk("fetch_req_n", {31'd0, mem_req}, 32'd0);
        cyc();
        mem_ready = 1; mem_rdata = 32'h8C220004;
        #1; chk("fetch_stall_busy", {31'd0, stall}, 32'd1);
        chk("fetch_req", {31'd0, mem_req}, 32'd1);
        chk("fetch_addr", mem_addr, 32'h40);
        chk("fetch_we", {31'd0, mem_we}, 32'd0);
        cyc();
        mem_ready = 0;
        #1; chk("fetch_stall_done", {31'd0, stall}, 32'd0);
        chk("fetch_req_done", {31'd0, mem_req}, 32'd0);
        chk("fetch_ir", ir, 32'h8C220004);
        chk("fetch_mdr", mdr, 32'd0);
        cyc();
        MemRead = 0; IRWrite = 0;
        #1; chk("fetch_idle_stall", {31'd0, stall}, 32'd0);
        cyc();

        // load with 3 wait states; ready lands on the terminal timeout cycle
        MemRead = 1; lorD = 1; alu_out = 32'h104; mem_rdata = 32'hDEADBEEF;
        #1; chk("load_stall_n", {31'd0, stall}, 32'd1);
        cyc();
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            #1; chk("load_req", {31'd0, mem_req}, 32'd1);
            chk("load_addr", mem_addr, 32'h104);
            chk("load_stall", {31'd0, stall}, 32'd1);
            cyc();
        end
        mem_ready = 0; MemRead = 0;
        #1; chk("load_req_done", {31'd0, mem_req}, 32'd0);
        chk("load_mdr", mdr, 32'hDEADBEEF);
        chk("load_ir", ir, 32'h8C220004);
        chk("load_err", {30'd0, err}, 32'd0);
        cyc();

        // store
        MemWrite = 1; alu_out = 32'h200; wdata = 32'h12345678; mem_rdata = 32'hFFFF0000;
        #1; chk("store_stall_n", {31'd0, stall}, 32'd1);
        cyc();
        mem_ready = 1;
        #1; chk("store_we", {31'd0, mem_we}, 32'd1);
        chk("store_wdata", mem_wdata, 32'h12345678);
        chk("store_addr", mem_addr, 32'h200);
        cyc();
        mem_ready = 0; MemWrite = 0;
        #1; chk("store_ir", ir, 32'h8C220004);
        chk("store_mdr", mdr, 32'hDEADBEEF);
        chk("store_req_done", {31'd0, mem_req}, 32'd0);
        cyc();

        // errors
        MemRead = 1; alu_out = 32'h102;
        #1; chk("align_stall", {31'd0, stall}, 32'd0);
        cyc();
        #1; chk("align_req", {31'd0, mem_req}, 32'd0);
        chk("align_err", {30'd0, err}, 32'd1);
        MemWrite = 1; alu_out = 32'h100;
        #1; chk("conf_stall", {31'd0, stall}, 32'd0);
        cyc();
        #1; chk("conf_sticky_err", {30'd0, err}, 32'd1);
        chk("conf_req", {31'd0, mem_req}, 32'd0);
        MemRead = 0; MemWrite = 0; err_clr = 1;
        cyc();
        err_clr = 0;
        #1; chk("clr_err", {30'd0, err}, 32'd0);
        MemRead = 1; MemWrite = 1;
        cyc();
        MemRead = 0; MemWrite = 0;
        #1; chk("conf_err", {30'd0, err}, 32'd2);
        err_clr = 1; MemRead = 1; alu_out = 32'h102;
        cyc();
        err_clr = 0; MemRead = 0;
        #1; chk("clr_newerr_wins", {30'd0, err}, 32'd1);
        err_clr = 1;
        cyc();
        err_clr = 0;
        #1; chk("clr_err2", {30'd0, err}, 32'd0);

        // timeout
        MemRead = 1; lorD = 0; pc = 32'h80; IRWrite = 0; mem_rdata = 32'h0BADF00D;
        cyc();
        for (int i = 0; i < 4; i++) begin
            #1; chk("to_req", {31'd0, mem_req}, 32'd1);
            chk("to_stall", {31'd0, stall}, 32'd1);
            cyc();
        end
        #1; chk("to_req_drop", {31'd0, mem_req}, 32'd0);
        chk("to_done_stall", {31'd0, stall}, 32'd0);
        chk("to_err", {30'd0, err}, 32'd3);
        chk("to_mdr", mdr, 32'hDEADBEEF);
        cyc();
        #1; chk("to_idle_stall", {31'd0, stall}, 32'd1);
        cyc();
        #1; chk("rstab_req_busy", {31'd0, mem_req}, 32'd1);

        // reset during BUSY
        rst = 0; MemRead = 0;
        #1; chk("rstab_req", {31'd0, mem_req}, 32'd0);
        chk("rstab_stall", {31'd0, stall}, 32'd0);
        chk("rstab_ir", ir, 32'd0);
        chk("rstab_mdr", mdr, 32'd0);
        chk("rstab_err", {30'd0, err}, 32'd0);
        rst = 1;
        cyc();
        MemRead = 1; IRWrite = 1; pc = 32'h44;
        #1; chk("post_stall", {31'd0, stall}, 32'd1);
        cyc();
        mem_ready = 1; mem_rdata = 32'h11112222;
        #1; chk("post_addr", mem_addr, 32'h44);
        chk("post_req", {31'd0, mem_req}, 32'd1);
        cyc();
        mem_ready = 0; MemRead = 0; IRWrite = 0;
        #1; chk("post_ir", ir, 32'h11112222);
        chk("post_mdr", mdr, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
